logic_gate_unit: RTL

Parametrised, pipelined multi-operand bitwise logic unit. It is the next generation of the team's two-input combinational gate: NUM_IN operands of WIDTH bits each, six selectable gate functions, a valid/ready handshake on both sides, and a two-stage registered pipeline. It sits between a stimulus/producer stage and a consumer, and adds a completed-transaction counter and a sticky illegal-opcode flag for bench and debug visibility.

---
 rtl/logic_gate_pkg.sv | 19 +
 rtl/logic_gate_reduce.sv | 43 ++++
 rtl/logic_gate_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/logic_gate_pkg.sv
// Shared op encodings and helpers for the multi-operand logic gate unit.
package logic_gate_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5
    } op_e;

    localparam logic [2:0] OP_LAST_LEGAL = 3'd5;

    function automatic logic op_illegal(input logic [2:0] op);
        return op > OP_LAST_LEGAL;
    endfunction

endpackage

// File: rtl/logic_gate_reduce.sv
// Combinational bitwise reduction of NUM_IN packed operands under a selected gate function.
module logic_gate_reduce
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_IN = 2
) (
    input  logic [NUM_IN*WIDTH-1:0] x_i,
    input  logic [2:0]              op_i,
    output logic [WIDTH-1:0]        result_o,
    output logic                    illegal_o
);

    logic [WIDTH-1:0] and_v;
    logic [WIDTH-1:0] or_v;
    logic [WIDTH-1:0] xor_v;

    always_comb begin
        and_v = '1;
        or_v  = '0;
        xor_v = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            and_v = and_v & x_i[k*WIDTH +: WIDTH];
            or_v  = or_v  | x_i[k*WIDTH +: WIDTH];
            xor_v = xor_v ^ x_i[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        result_o  = '0;
        illegal_o = op_illegal(op_i);
        case (op_e'(op_i))
            OP_AND:  result_o = and_v;
            OP_OR:   result_o = or_v;
            OP_XOR:  result_o = xor_v;
            OP_NAND: result_o = ~and_v;
            OP_NOR:  result_o = ~or_v;
            OP_XNOR: result_o = ~xor_v;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/logic_gate_unit.sv
// Two-stage valid/ready pipeline around logic_gate_reduce, with a saturating
// completion counter and a sticky illegal-op flag.
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_IN = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] x,
    input  logic [2:0]              op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        z,
    output logic                    z_any,
    output logic [15:0]             op_count,
    output logic                    err
);

    logic                    s1_valid_q, s1_valid_d;
    logic [NUM_IN*WIDTH-1:0] s1_x_q, s1_x_d;
    logic [2:0]              s1_op_q, s1_op_d;
    logic                    s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0]        z_q, z_d;
    logic                    z_any_q, z_any_d;
    logic [15:0]             op_count_q, op_count_d;
    logic                    err_q, err_d;

    logic             s2_free;
    logic             s1_adv;
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] red_result;
    logic             red_illegal;

    logic_gate_reduce #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_reduce (
        .x_i       (s1_x_q),
        .op_i      (s1_op_q),
        .result_o  (red_result),
        .illegal_o (red_illegal)
    );

    // Ready depends only on registered state and out_ready, never on in_valid.
    assign s2_free  = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid_q && out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_op_d    = s1_op_q;
        s2_valid_d = s2_valid_q;
        z_d        = z_q;
        z_any_d    = z_any_q;
        op_count_d = op_count_q;
        err_d      = err_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_x_d     = x;
            s1_op_d    = op;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s2_free) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                z_d     = red_illegal ? '0 : red_result;
                z_any_d = !red_illegal && (|red_result);
            end
        end

        if (out_fire && (op_count_q != 16'hFFFF)) begin
            op_count_d = op_count_q + 16'd1;
        end

        if (in_fire && op_illegal(op)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            z_q        <= '0;
            z_any_q    <= 1'b0;
            op_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            z_q        <= z_d;
            z_any_q    <= z_any_d;
            op_count_q <= op_count_d;
            err_q      <= err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign z         = z_q;
    assign z_any     = z_any_q;
    assign op_count  = op_count_q;
    assign err       = err_q;

endmodule
